// File: rtl/sensor_event_arbiter_if.sv
// Event handshake between the arbiter FIFO head and the screen controller.
// The master side produces events; the slave side consumes them.
interface sensor_event_arbiter_if;
    logic       evt_valid;
    logic [2:0] evt_code;
    logic       evt_ready;

    modport master (output evt_valid, output evt_code, input evt_ready);
    modport slave  (input evt_valid, input evt_code, output evt_ready);
endinterface

// File: rtl/sensor_event_arbiter.sv
// Per-source rise detection and hold-off, round-robin grant into a small event FIFO,
// drained by the screen controller over a valid/ready handshake.
module sensor_event_lane #(
    parameter int unsigned HOLDOFF_CYC = 1_000_000,
    parameter int          HO_W        = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_src,
    input  logic i_grant,
    output logic o_pend,
    output logic o_merge
);
    logic            r_prev;
    logic            r_pend;
    logic [HO_W-1:0] r_ho_cnt;
    logic            w_rise;
    logic            w_accept;

    // A rise in the source's own grant cycle is swallowed, as is any rise during hold-off.
    assign w_rise   = i_src & ~r_prev;
    assign w_accept = w_rise && (r_ho_cnt == '0) && !i_grant;
    assign o_merge  = w_accept && r_pend;
    assign o_pend   = r_pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev   <= 1'b0;
            r_pend   <= 1'b0;
            r_ho_cnt <= '0;
        end else begin
            r_prev <= i_src;
            if (i_clr) begin
                r_pend   <= 1'b0;
                r_ho_cnt <= '0;
            end else if (i_grant) begin
                r_pend   <= 1'b0;
                r_ho_cnt <= HO_W'(HOLDOFF_CYC);
            end else begin
                if (w_accept)
                    r_pend <= 1'b1;
                if (r_ho_cnt != '0)
                    r_ho_cnt <= r_ho_cnt - HO_W'(1);
            end
        end
    end
endmodule

module sensor_event_arbiter #(
    parameter int unsigned HOLDOFF_CYC = 1_000_000,
    parameter int          FIFO_DEPTH  = 4,
    parameter int          HO_W        = 20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic [7:0]            src_in,
    sensor_event_arbiter_if.master evt,
    output logic [7:0]            pend_o,
    output logic                  ovf
);
    localparam int NUM_SRC = 8;
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = AW + 1;

    logic [NUM_SRC-1:0] w_pend;
    logic [NUM_SRC-1:0] w_merge;
    logic [NUM_SRC-1:0] w_gnt_vec;
    logic [2:0]         w_gnt_idx;
    logic               w_found;
    logic               w_grant;
    logic               w_pop;
    logic               w_valid;

    logic [2:0]         r_rr_ptr;
    logic               r_ovf;
    logic [2:0]         r_mem [FIFO_DEPTH];
    logic [AW-1:0]      r_wr_ptr;
    logic [AW-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_lane
        sensor_event_lane #(.HOLDOFF_CYC(HOLDOFF_CYC), .HO_W(HO_W)) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_clr   (clr),
            .i_src   (src_in[g]),
            .i_grant (w_gnt_vec[g]),
            .o_pend  (w_pend[g]),
            .o_merge (w_merge[g])
        );
    end

    // Round-robin scan starting at r_rr_ptr.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = 3'd0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!w_found && w_pend[r_rr_ptr + 3'(k)]) begin
                w_found   = 1'b1;
                w_gnt_idx = r_rr_ptr + 3'(k);
            end
        end
    end

    assign w_valid   = (r_count != '0);
    assign w_pop     = w_valid && evt.evt_ready;
    // A pop frees a slot in the same cycle, so a full FIFO can still accept a grant.
    assign w_grant   = w_found && ((r_count < CNT_W'(FIFO_DEPTH)) || w_pop);
    assign w_gnt_vec = w_grant ? (NUM_SRC'(1) << w_gnt_idx) : '0;

    assign evt.evt_valid = w_valid;
    assign evt.evt_code  = r_mem[r_rd_ptr];
    assign pend_o        = w_pend;
    assign ovf           = r_ovf;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= 3'd0;
            r_ovf    <= 1'b0;
        end else if (clr) begin
            r_rr_ptr <= 3'd0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_grant)
                r_rr_ptr <= w_gnt_idx + 3'd1;
            if (w_merge != '0)
                r_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                r_mem[i] <= 3'd0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_grant) begin
                r_mem[r_wr_ptr] <= w_gnt_idx;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + CNT_W'(w_grant) - CNT_W'(w_pop);
        end
    end
endmodule

// File: tb/tb_sensor_event_arbiter.sv
// Directed scenarios plus random traffic, compared each cycle against a queue-based model.
module tb_sensor_event_arbiter;
    localparam int H = 20;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] src_in = 8'h00;
    logic [7:0] pend_o;
    logic       ovf;

    sensor_event_arbiter_if evt ();

    sensor_event_arbiter #(.HOLDOFF_CYC(H), .FIFO_DEPTH(D), .HO_W(8)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (clr),
        .src_in (src_in),
        .evt    (evt),
        .pend_o (pend_o),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    bit [7:0] m_prev;
    bit [7:0] m_pend;
    int       m_ho [8];
    int       m_q [$];
    int       m_rr;
    bit       m_ovf;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        m_prev = 0; m_pend = 0; m_rr = 0; m_ovf = 0;
        m_q.delete();
        for (int i = 0; i < 8; i++) m_ho[i] = 0;
    endtask

    // Applies the rules for one clock edge using the inputs currently driven.
    task automatic m_step();
        bit [7:0] rise, newset;
        bit       pop, g, found;
        int       win;
        rise   = src_in & ~m_prev;
        m_prev = src_in;
        newset = 0;
        if (clr) begin
            m_pend = 0; m_rr = 0; m_ovf = 0;
            m_q.delete();
            for (int i = 0; i < 8; i++) m_ho[i] = 0;
            return;
        end
        pop   = (m_q.size() != 0) && evt.evt_ready;
        g     = (m_pend != 0) && ((m_q.size() < D) || pop);
        win   = -1;
        found = 0;
        if (g)
            for (int k = 0; k < 8; k++)
                if (!found && m_pend[(m_rr + k) % 8]) begin
                    found = 1;
                    win   = (m_rr + k) % 8;
                end
        for (int i = 0; i < 8; i++) begin
            if (rise[i] && m_ho[i] == 0 && i != win) begin
                if (m_pend[i]) m_ovf = 1;
                else newset[i] = 1;
            end
            if (i == win) m_ho[i] = H;
            else if (m_ho[i] > 0) m_ho[i]--;
        end
        if (pop) void'(m_q.pop_front());
        if (g) begin
            m_q.push_back(win);
            m_pend[win] = 0;
            m_rr = (win + 1) % 8;
        end
        m_pend |= newset;
    endtask

    task automatic check_all();
        chk("evt_valid", evt.evt_valid, (m_q.size() != 0));
        if (m_q.size() != 0) chk("evt_code", evt.evt_code, m_q[0]);
        chk("pend_o", pend_o, m_pend);
        chk("ovf", ovf, m_ovf);
    endtask

    task automatic tick();
        m_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clr_pulse();
        clr = 1'b1; tick(); clr = 1'b0;
    endtask

    initial begin
        m_reset();
        evt.evt_ready = 1'b1;
        src_in = 8'h08;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("rst_code", evt.evt_code, 0);
        rst_n = 1'b1;
        // source 3 was high through reset: one event expected
        tick();
        chk("rst_rise_pend", pend_o, 8'h08);
        tick();
        chk("rst_rise_code", evt.evt_code, 3);
        src_in = 8'h00;
        ticks(25);

        // single event latency and one-cycle valid
        ticks(9);
        src_in = 8'h02;
        tick();
        chk("t1_pend", pend_o, 8'h02);
        tick();
        chk("t1_valid", evt.evt_valid, 1);
        chk("t1_code", evt.evt_code, 1);
        tick();
        chk("t1_valid_off", evt.evt_valid, 0);
        src_in = 8'h00;
        ticks(25);

        // round-robin order from rr_ptr=0
        clr_pulse();
        evt.evt_ready = 1'b0;
        src_in = 8'h49;
        ticks(4);
        chk("t2_head0", evt.evt_code, 0);
        evt.evt_ready = 1'b1;
        tick();
        chk("t2_head3", evt.evt_code, 3);
        tick();
        chk("t2_head6", evt.evt_code, 6);
        tick();
        chk("t2_empty", evt.evt_valid, 0);
        src_in = 8'h00;
        ticks(25);

        // rr_ptr=7 after granting 6: source 7 precedes source 0
        src_in = 8'h81;
        ticks(2);
        chk("t3_first7", evt.evt_code, 7);
        tick();
        chk("t3_then0", evt.evt_code, 0);
        src_in = 8'h00;
        ticks(25);

        // hold-off drop then later delivery
        src_in = 8'h04;
        ticks(2);
        src_in = 8'h00;
        ticks(3);
        src_in = 8'h04;
        tick();
        chk("t4_drop_pend", pend_o, 0);
        chk("t4_drop_ovf", ovf, 0);
        src_in = 8'h00;
        ticks(20);
        src_in = 8'h04;
        ticks(2);
        chk("t4_deliver", evt.evt_code, 2);
        chk("t4_valid", evt.evt_valid, 1);
        src_in = 8'h00;
        ticks(25);

        // back-pressure, merge overflow, clear
        clr_pulse();
        evt.evt_ready = 1'b0;
        src_in = 8'h3F;
        ticks(6);
        chk("t5_pend_held", pend_o, 8'h30);
        src_in = 8'h2F;
        tick();
        src_in = 8'h3F;
        tick();
        chk("t5_ovf", ovf, 1);
        clr_pulse();
        chk("t5_clr_pend", pend_o, 0);
        chk("t5_clr_valid", evt.evt_valid, 0);
        chk("t5_clr_ovf", ovf, 0);
        src_in = 8'h00;
        ticks(25);

        // async reset mid-handshake
        clr_pulse();
        evt.evt_ready = 1'b0;
        src_in = 8'h07;
        ticks(5);
        chk("t6_valid_before", evt.evt_valid, 1);
        evt.evt_ready = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("t6_rst_valid", evt.evt_valid, 0);
        chk("t6_rst_pend", pend_o, 0);
        chk("t6_rst_ovf", ovf, 0);
        src_in = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        ticks(10);
        chk("t6_no_event", evt.evt_valid, 0);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            src_in = src_in ^ (8'($urandom) & 8'($urandom));
            evt.evt_ready = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 60) == 0);
            tick();
        end
        clr = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
